// File: rtl/adc_ltc2308_scan.sv
// LTC2308 scan sequencer: round-robins over the enabled channels, drives
// CONVST and the 12-bit SPI frame, and realigns the ADC's one-frame result
// pipeline so each result lands in the bank slot of the channel it belongs to.
// CONV_CYCLES is assumed to be at least 1, like the other cycle counts.
module adc_ltc2308_scan #(
    parameter int CLK_DIV       = 2,
    parameter int CONVST_CYCLES = 4,
    parameter int CONV_CYCLES   = 80,
    parameter int GAP_CYCLES    = 2,
    parameter bit UNIPOLAR      = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [7:0]  ch_mask,
    input  logic [2:0]  rd_addr,
    output logic [11:0] rd_data,
    output logic [7:0]  valid_mask,
    output logic        sample_strobe,
    output logic [2:0]  sample_ch,
    output logic        adc_convst,
    output logic        adc_sck,
    output logic        adc_sdi,
    input  logic        adc_sdo
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CONV_HI   = 3'd1,
        ST_CONV_WAIT = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_GAP       = 3'd4
    } state_t;

    localparam logic [15:0] CONVST_LAST = 16'(CONVST_CYCLES - 1);
    localparam logic [15:0] CONV_LAST   = 16'(CONV_CYCLES - 1);
    localparam logic [15:0] GAP_LAST    = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] DIV_LAST    = 16'(CLK_DIV - 1);

    // Config word sent MSB first: S/D, O/S, S1, S0, UNI, SLP.
    function automatic logic [5:0] cfg_word(input logic [2:0] ch);
        return {1'b1, ch[0], ch[2], ch[1], UNIPOLAR, 1'b0};
    endfunction

    // First set mask bit at or after ptr, wrapping 7 -> 0.
    function automatic logic [2:0] pick_channel(input logic [7:0] mask, input logic [2:0] ptr);
        logic [2:0] idx;
        logic [2:0] sel;
        logic       found;
        sel   = ptr;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = ptr + 3'(k);
            if (!found && mask[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    state_t      state_r;
    logic [15:0] cnt_r;
    logic [15:0] div_r;
    logic [3:0]  bit_r;
    logic        phase_r;
    logic [2:0]  ptr_r;
    logic [2:0]  cur_ch_r;
    logic [2:0]  prev_ch_r;
    logic        prev_valid_r;
    logic [5:0]  cfg_sr_r;
    logic [10:0] shreg_r;
    logic [11:0] bank_r [8];
    logic        en_prev_r;
    logic        convst_r;
    logic        sck_r;
    logic        sdi_r;
    logic        strobe_r;
    logic [2:0]  sample_ch_r;
    logic [7:0]  valid_r;
    logic [11:0] rd_data_r;

    logic        start_ok_s;
    logic [2:0]  sel_ch_s;

    // Frame-start decision shared by IDLE exit and GAP end.
    always_comb begin
        start_ok_s = enable && (ch_mask != 8'h00);
        sel_ch_s   = pick_channel(ch_mask, ptr_r);
    end

    // Scan FSM: CONVST timing, SPI shifting, pipeline realignment and bank writes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 16'd0;
            div_r        <= 16'd0;
            bit_r        <= 4'd0;
            phase_r      <= 1'b0;
            ptr_r        <= 3'd0;
            cur_ch_r     <= 3'd0;
            prev_ch_r    <= 3'd0;
            prev_valid_r <= 1'b0;
            cfg_sr_r     <= 6'd0;
            shreg_r      <= 11'd0;
            en_prev_r    <= 1'b0;
            convst_r     <= 1'b0;
            sck_r        <= 1'b0;
            sdi_r        <= 1'b0;
            strobe_r     <= 1'b0;
            sample_ch_r  <= 3'd0;
            valid_r      <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                bank_r[i] <= 12'h000;
            end
        end else begin
            strobe_r  <= 1'b0;
            en_prev_r <= enable;
            case (state_r)
                ST_IDLE: begin
                    convst_r <= 1'b0;
                    sck_r    <= 1'b0;
                    sdi_r    <= 1'b0;
                    if (enable && !en_prev_r) begin
                        valid_r <= 8'h00;
                    end
                    if (start_ok_s) begin
                        state_r  <= ST_CONV_HI;
                        cur_ch_r <= sel_ch_s;
                        ptr_r    <= sel_ch_s + 3'd1;
                        cfg_sr_r <= cfg_word(sel_ch_s);
                        convst_r <= 1'b1;
                        cnt_r    <= 16'd0;
                    end
                end
                ST_CONV_HI: begin
                    if (cnt_r == CONVST_LAST) begin
                        convst_r <= 1'b0;
                        cnt_r    <= 16'd0;
                        state_r  <= ST_CONV_WAIT;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_CONV_WAIT: begin
                    if (cnt_r == CONV_LAST) begin
                        state_r  <= ST_SHIFT;
                        cnt_r    <= 16'd0;
                        div_r    <= 16'd0;
                        bit_r    <= 4'd0;
                        phase_r  <= 1'b0;
                        sck_r    <= 1'b0;
                        sdi_r    <= cfg_sr_r[5];
                        cfg_sr_r <= {cfg_sr_r[4:0], 1'b0};
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_SHIFT: begin
                    if (div_r != DIV_LAST) begin
                        div_r <= div_r + 16'd1;
                    end else if (!phase_r) begin
                        div_r   <= 16'd0;
                        phase_r <= 1'b1;
                        sck_r   <= 1'b1;
                    end else begin
                        // Last cycle of the high phase: capture SDO, drop SCK.
                        div_r   <= 16'd0;
                        phase_r <= 1'b0;
                        sck_r   <= 1'b0;
                        shreg_r <= {shreg_r[9:0], adc_sdo};
                        if (bit_r == 4'd11) begin
                            state_r <= ST_GAP;
                            cnt_r   <= 16'd0;
                            sdi_r   <= 1'b0;
                            // This frame's data belongs to the previous frame's channel.
                            if (prev_valid_r) begin
                                bank_r[prev_ch_r]  <= {shreg_r, adc_sdo};
                                valid_r[prev_ch_r] <= 1'b1;
                                strobe_r           <= 1'b1;
                                sample_ch_r        <= prev_ch_r;
                            end
                            prev_ch_r    <= cur_ch_r;
                            prev_valid_r <= 1'b1;
                        end else begin
                            bit_r    <= bit_r + 4'd1;
                            sdi_r    <= cfg_sr_r[5];
                            cfg_sr_r <= {cfg_sr_r[4:0], 1'b0};
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt_r == GAP_LAST) begin
                        cnt_r <= 16'd0;
                        if (start_ok_s) begin
                            state_r  <= ST_CONV_HI;
                            cur_ch_r <= sel_ch_s;
                            ptr_r    <= sel_ch_s + 3'd1;
                            cfg_sr_r <= cfg_word(sel_ch_s);
                            convst_r <= 1'b1;
                        end else begin
                            // Restart must begin with a dummy frame.
                            state_r      <= ST_IDLE;
                            prev_valid_r <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    convst_r     <= 1'b0;
                    sck_r        <= 1'b0;
                    sdi_r        <= 1'b0;
                    prev_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Registered bank read; a same-cycle write is seen one cycle later.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data_r <= 12'h000;
        end else begin
            rd_data_r <= bank_r[rd_addr];
        end
    end

    assign rd_data       = rd_data_r;
    assign valid_mask    = valid_r;
    assign sample_strobe = strobe_r;
    assign sample_ch     = sample_ch_r;
    assign adc_convst    = convst_r;
    assign adc_sck       = sck_r;
    assign adc_sdi       = sdi_r;

endmodule
